// File: rtl/sram_pkg.sv
// Shared types for the SRAM arbiter: sequencer states and grant encoding.
package sram_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sram_arbiter_if.sv
// One requestor port of the SRAM arbiter: req/ack handshake plus address and data.
interface sram_arbiter_if #(
  parameter int unsigned AW = 21
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic          ack;

  modport master (output req, we, addr, din, input dout, ack);
  modport slave  (input req, we, addr, din, output dout, ack);
endinterface

// File: rtl/sram_rr_grant.sv
// Two-way round-robin picker; the last_grant register is owned by the caller.
module sram_rr_grant
  import sram_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  grant_e last_grant,
  output logic   grant_valid,
  output grant_e grant_sel
);

  always_comb begin
    grant_valid = req_a | req_b;
    if (req_a && req_b) begin
      grant_sel = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
    end else if (req_a) begin
      grant_sel = GRANT_A;
    end else begin
      grant_sel = GRANT_B;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for the external 8-bit SRAM: SETUP, STROBE xN, HOLD per access.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned AW         = 21,
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic          clock,
  input  logic          reset,
  sram_arbiter_if.slave a_port,
  sram_arbiter_if.slave b_port,
  output logic [AW-1:0] SRAM_ADDR,
  inout  wire  [7:0]    SRAM_DATA,
  output logic          SRAM_WE_n,
  output logic          SRAM_OE_n
);

  state_e           state_q, state_d;
  grant_e           last_grant_q, sel_q, grant_sel;
  logic             grant_valid;
  logic             we_q;
  logic [7:0]       wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             data_drive;

  sram_rr_grant u_grant (
    .req_a       (a_port.req),
    .req_b       (b_port.req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  assign SRAM_DATA = data_drive ? wdata_q : 'z;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_valid) state_d = S_SETUP;
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: if (cnt_q == '0) state_d = S_HOLD;
      S_HOLD:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Port inputs are sampled only on grant; the latched copies drive the whole access.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= GRANT_B;
      sel_q        <= GRANT_A;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      SRAM_ADDR    <= '0;
      a_port.dout  <= '0;
      b_port.dout  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_valid) begin
            sel_q        <= grant_sel;
            last_grant_q <= grant_sel;
            we_q         <= (grant_sel == GRANT_A) ? a_port.we   : b_port.we;
            wdata_q      <= (grant_sel == GRANT_A) ? a_port.din  : b_port.din;
            SRAM_ADDR    <= (grant_sel == GRANT_A) ? a_port.addr : b_port.addr;
          end
        end
        S_SETUP: cnt_q <= CNT_W'(STROBE_CYC - 1);
        S_STROBE: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0 && !we_q) begin
            if (sel_q == GRANT_A) a_port.dout <= SRAM_DATA;
            else                  b_port.dout <= SRAM_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    SRAM_WE_n   = 1'b1;
    SRAM_OE_n   = 1'b1;
    data_drive  = 1'b0;
    a_port.ack  = 1'b0;
    b_port.ack  = 1'b0;
    case (state_q)
      S_SETUP: begin
        data_drive = we_q;
        SRAM_OE_n  = we_q;
      end
      S_STROBE: begin
        data_drive = we_q;
        SRAM_WE_n  = !we_q;
        SRAM_OE_n  = we_q;
      end
      S_HOLD: begin
        data_drive = we_q;
        a_port.ack = (sel_q == GRANT_A);
        b_port.ack = (sel_q == GRANT_B);
      end
      default: ;
    endcase
  end

endmodule
